// File: rtl/i2s_rx_deserializer_if.sv
// rtl/i2s_rx_deserializer_if.sv - I2S serial inputs and decoded L/R sample outputs (mono_q with I2S_MONO_MIX_EN)
interface i2s_rx_deserializer_if #(
    parameter int BIT_WIDTH = 24
);
    logic                        i2s_bclk;
    logic                        i2s_lrclk;
    logic                        i2s_sdata;
    logic signed [BIT_WIDTH-1:0] left_q;
    logic signed [BIT_WIDTH-1:0] right_q;
    logic                        sample_valid;
    logic                        frame_err;
`ifdef I2S_MONO_MIX_EN
    logic signed [BIT_WIDTH-1:0] mono_q;

    modport master (
        output i2s_bclk, i2s_lrclk, i2s_sdata,
        input  left_q, right_q, sample_valid, frame_err, mono_q
    );
    modport slave (
        input  i2s_bclk, i2s_lrclk, i2s_sdata,
        output left_q, right_q, sample_valid, frame_err, mono_q
    );
`else
    modport master (
        output i2s_bclk, i2s_lrclk, i2s_sdata,
        input  left_q, right_q, sample_valid, frame_err
    );
    modport slave (
        input  i2s_bclk, i2s_lrclk, i2s_sdata,
        output left_q, right_q, sample_valid, frame_err
    );
`endif
endinterface

// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - oversampling I2S receiver producing paired L/R samples; optional mono mix via I2S_MONO_MIX_EN
module i2s_rx_deserializer #(
    parameter int BIT_WIDTH   = 24,
    parameter int RANGE       = BIT_WIDTH - 1,
    parameter int SLOT_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    i2s_rx_deserializer_if.slave  bus
);

    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(BIT_WIDTH - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } state_t;

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   bclk_s;
    logic                   lr_s;
    logic                   sd_s;
    logic                   bclk_prev;
    logic                   lr_prev;
    logic                   ev;
    logic                   lr_chg;

    state_t                 state;
    state_t                 state_nxt;
    logic                   start;
    logic                   shift_en;
    logic                   cnt_inc;
    logic                   word_done;
    logic                   err;

    logic [CW-1:0]          bit_cnt;
    logic                   chan;
    logic [RANGE-1:0]       shift_reg;
    logic [RANGE:0]         word;
    logic [RANGE:0]         hold;
    logic                   left_ok;

    // Reset asserts immediately but releases only on a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Bring the asynchronous I2S lines into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            sd_sync   <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bus.i2s_bclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], bus.i2s_lrclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], bus.i2s_sdata};
            bclk_prev <= bclk_s;
        end
    end

    assign bclk_s = bclk_sync[SYNC_STAGES-1];
    assign lr_s   = lr_sync[SYNC_STAGES-1];
    assign sd_s   = sd_sync[SYNC_STAGES-1];
    assign ev     = bclk_s & ~bclk_prev;
    assign lr_chg = ev & (lr_s ^ lr_prev);
    assign word   = {shift_reg, sd_s};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: only a left-slot start leaves IDLE so pairs always begin with L
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lr_chg && !lr_s) state_nxt = SHIFT;
            SHIFT:   if (lr_chg)          state_nxt = SHIFT;
                     else if (word_done)  state_nxt = PAD;
            PAD:     if (lr_chg)          state_nxt = SHIFT;
                     else if (err)        state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Per-event control strobes for the datapath
    always_comb begin
        start     = 1'b0;
        shift_en  = 1'b0;
        cnt_inc   = 1'b0;
        word_done = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (lr_chg && !lr_s) start = 1'b1;
            end
            SHIFT: begin
                if (lr_chg) begin
                    err   = 1'b1;
                    start = 1'b1;
                end else if (ev) begin
                    shift_en  = 1'b1;
                    cnt_inc   = 1'b1;
                    word_done = (bit_cnt == LAST_BIT);
                end
            end
            PAD: begin
                if (lr_chg) begin
                    start = 1'b1;
                end else if (ev) begin
                    cnt_inc = 1'b1;
                    err     = (bit_cnt == LAST_SLOT);
                end
            end
            default: ;
        endcase
    end

    // Bit counter, channel tag and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_prev   <= 1'b0;
            bit_cnt   <= '0;
            chan      <= 1'b0;
            shift_reg <= '0;
        end else begin
            if (ev) lr_prev <= lr_s;
            if (start) begin
                bit_cnt   <= '0;
                chan      <= lr_s;
                shift_reg <= '0;
            end else begin
                if (cnt_inc)  bit_cnt   <= bit_cnt + 1'b1;
                if (shift_en) shift_reg <= word[RANGE-1:0];
            end
        end
    end

    // Pair assembly and output registers; errors drop any half-built pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold             <= '0;
            left_ok          <= 1'b0;
            bus.left_q       <= '0;
            bus.right_q      <= '0;
            bus.sample_valid <= 1'b0;
            bus.frame_err    <= 1'b0;
`ifdef I2S_MONO_MIX_EN
            bus.mono_q       <= '0;
`endif
        end else begin
            bus.sample_valid <= 1'b0;
            bus.frame_err    <= err;
            if (err) begin
                left_ok <= 1'b0;
            end else if (word_done) begin
                if (!chan) begin
                    hold    <= word;
                    left_ok <= 1'b1;
                end else if (left_ok) begin
                    bus.left_q       <= hold;
                    bus.right_q      <= word;
                    bus.sample_valid <= 1'b1;
                    left_ok          <= 1'b0;
`ifdef I2S_MONO_MIX_EN
                    bus.mono_q <= BIT_WIDTH'({hold[RANGE], hold[RANGE], hold[RANGE:1]}
                                           + {word[RANGE], word[RANGE], word[RANGE:1]});
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - directed bench for i2s_rx_deserializer
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   passed = 0;
    int   sv_cnt = 0;
    int   fe_cnt = 0;
    int   both_cnt = 0;
    int   sv_base;
    int   fe_base;
    real  lsb_time = 0.0;
    real  sv_time = 0.0;
    logic lat_ok;

    i2s_rx_deserializer_if #(.BIT_WIDTH(24)) bus ();

    i2s_rx_deserializer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sample_valid) begin
            sv_cnt++;
            sv_time = $realtime;
        end
        if (bus.frame_err) fe_cnt++;
        if (bus.sample_valid && bus.frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
        #0.5;
    endtask

    task automatic snap();
        sv_base = sv_cnt;
        fe_base = fe_cnt;
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] data, input int len);
        for (int i = 0; i < len; i++) begin
            bus.i2s_lrclk = lr;
            bus.i2s_sdata = (i >= 1 && i <= 24) ? data[24-i] : 1'b0;
            #163;
            bus.i2s_bclk = 1'b1;
            if (lr && i == 24) lsb_time = $realtime;
            #163;
            bus.i2s_bclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
        gap(4);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.i2s_bclk  = 1'b0;
        bus.i2s_lrclk = 1'b0;
        bus.i2s_sdata = 1'b0;
        gap(3);
        #1;
        check("reset_left", bus.left_q, 24'h0);
        check("reset_right", bus.right_q, 24'h0);
        check("reset_valid", 24'(bus.sample_valid), 24'h0);
        check("reset_err", 24'(bus.frame_err), 24'h0);
`ifdef I2S_MONO_MIX_EN
        check("reset_mono", bus.mono_q, 24'h0);
`endif
        reset_n = 1'b1;
        gap(4);

        // stream joins mid right slot
        snap();
        send_slot(1'b1, 24'hABCDEF, 10);
        gap(4);
        check("mid_right_no_strobe", 24'(sv_cnt - sv_base), 24'd0);

        // first full pair; strobe lands 3 clk after the right LSB edge, seen at next negedge
        snap();
        send_frame(24'h123456, 24'hFEDCBA);
        check("f1_strobes", 24'(sv_cnt - sv_base), 24'd1);
        check("f1_left", bus.left_q, 24'h123456);
        check("f1_right", bus.right_q, 24'hFEDCBA);
        check("f1_err", 24'(fe_cnt - fe_base), 24'd0);
        lat_ok = (sv_time - lsb_time > 50.0) && (sv_time - lsb_time < 70.0);
        check("f1_latency", 24'(lat_ok), 24'd1);

        // extreme values
        snap();
        send_frame(24'h7FFFFF, 24'h800000);
        check("f2_strobes", 24'(sv_cnt - sv_base), 24'd1);
        check("f2_left", bus.left_q, 24'h7FFFFF);
        check("f2_right", bus.right_q, 24'h800000);

        // left slot cut to 16 bclks
        snap();
        send_slot(1'b0, 24'h0F0F0F, 16);
        send_slot(1'b1, 24'h313131, 32);
        gap(4);
        check("trunc_err", 24'(fe_cnt - fe_base), 24'd1);
        check("trunc_no_strobe", 24'(sv_cnt - sv_base), 24'd0);
        check("trunc_left_held", bus.left_q, 24'h7FFFFF);
        check("trunc_right_held", bus.right_q, 24'h800000);
        snap();
        send_frame(24'h0A0B0C, 24'hF0E0D0);
        check("post_trunc_strobes", 24'(sv_cnt - sv_base), 24'd1);
        check("post_trunc_left", bus.left_q, 24'h0A0B0C);
        check("post_trunc_right", bus.right_q, 24'hF0E0D0);
        check("post_trunc_err", 24'(fe_cnt - fe_base), 24'd0);

        // lrclk stuck low for 40 bclks
        snap();
        send_slot(1'b0, 24'h555555, 40);
        gap(4);
        check("stuck_err", 24'(fe_cnt - fe_base), 24'd1);
        check("stuck_no_strobe", 24'(sv_cnt - sv_base), 24'd0);
        snap();
        send_slot(1'b1, 24'h777777, 32);
        send_frame(24'h111111, 24'h222222);
        check("recover_strobes", 24'(sv_cnt - sv_base), 24'd1);
        check("recover_left", bus.left_q, 24'h111111);
        check("recover_right", bus.right_q, 24'h222222);
        check("recover_err", 24'(fe_cnt - fe_base), 24'd0);

        // reset during a right slot
        send_slot(1'b0, 24'h333333, 32);
        send_slot(1'b1, 24'h444444, 12);
        reset_n = 1'b0;
        #1;
        check("rst_left", bus.left_q, 24'h0);
        check("rst_right", bus.right_q, 24'h0);
        check("rst_valid", 24'(bus.sample_valid), 24'h0);
        check("rst_err", 24'(bus.frame_err), 24'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        gap(4);
        snap();
        send_slot(1'b1, 24'h000000, 20);
        gap(4);
        check("post_rst_no_strobe", 24'(sv_cnt - sv_base), 24'd0);
        check("post_rst_left", bus.left_q, 24'h0);
        snap();
        send_frame(24'h654321, 24'hABCDEF);
        check("post_rst_strobes", 24'(sv_cnt - sv_base), 24'd1);
        check("post_rst_left2", bus.left_q, 24'h654321);
        check("post_rst_right2", bus.right_q, 24'hABCDEF);

`ifdef I2S_MONO_MIX_EN
        send_frame(24'h400000, 24'h200000);
        check("mono_mix", bus.mono_q, 24'h300000);
        send_frame(24'h800000, 24'h800000);
        check("mono_neg_full", bus.mono_q, 24'h800000);
`endif

        check("valid_err_overlap", 24'(both_cnt), 24'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
